// File: rtl/muneco_pkg.sv
// Shared encodings and screen geometry for the muneco character controller.
package muneco_pkg;

    typedef enum logic [1:0] {
        ST_STAND = 2'd0,
        ST_JUMP  = 2'd1,
        ST_FALL  = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    localparam int unsigned MUN_XL = 42;
    localparam int unsigned MUN_XR = 45;
    localparam int unsigned MAX_X  = 640;
    localparam int unsigned MAX_Y  = 480;

endpackage

// File: rtl/muneco_if.sv
// Frame/pixel/control bundle between the game logic (master) and muneco_ctrl (slave).
interface muneco_if;

    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       refr_tick;
    logic       btn_jump;
    logic [2:0] color_sel;
    logic       stand;
    logic       over;
    logic [9:0] munyt;
    logic [9:0] munyb;
    logic [2:0] mun_rgb;
    logic       mun_on;
    logic       dead;

    modport master (
        output pix_x, pix_y, refr_tick, btn_jump, color_sel, stand, over,
        input  munyt, munyb, mun_rgb, mun_on, dead
    );

    modport slave (
        input  pix_x, pix_y, refr_tick, btn_jump, color_sel, stand, over,
        output munyt, munyb, mun_rgb, mun_on, dead
    );

endinterface

// File: rtl/btn_edge.sv
// Two-flop button register with a one-clock rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [1:0] btn_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= 2'b00;
        end else begin
            btn_q <= {btn_q[0], btn};
        end
    end

    assign pulse = btn_q[0] & ~btn_q[1];

endmodule

// File: rtl/muneco_ctrl.sv
// Vertical motion, colour and game-over control for the muneco character.
// Optional MUNECO_DOUBLE_JUMP_EN allows one extra jump per airborne period.
module muneco_ctrl
    import muneco_pkg::*;
#(
    parameter int unsigned MUN_Y_SIZE = 8,
    parameter int unsigned Y_START    = 100,
    parameter int unsigned JUMP_V0    = 8,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned VMAX_FALL  = 3,
    parameter logic [2:0]  COLOR_RST  = 3'b100
) (
    input logic     clk,
    input logic     reset,
    muneco_if.slave bus
);

    localparam logic [3:0]  V0   = 4'(JUMP_V0);
    localparam logic [3:0]  G    = 4'(GRAVITY);
    localparam logic [3:0]  VMAX = 4'(VMAX_FALL);
    localparam logic [10:0] YMAX = 11'(MAX_Y - 1);
    localparam logic [10:0] YEXT = 11'(MUN_Y_SIZE - 1);

    state_t      state_q;
    logic [9:0]  munyt_q;
    logic [3:0]  vy_q;
    logic        jump_req_q;
    logic [2:0]  rgb_q;
    logic        dead_q;
    logic        jump_pulse;
    logic [10:0] y_up;
    logic [10:0] y_launch;
    logic [10:0] y_down;
    logic [4:0]  vy_sum;
    logic [3:0]  vy_fall;
    logic        down_oob;
    logic        air_jump;
    logic        launch;

    btn_edge u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_jump),
        .pulse (jump_pulse)
    );

    // 11-bit position maths: bit 10 flags an upward underflow.
    assign y_up     = {1'b0, munyt_q} - {7'd0, vy_q};
    assign y_launch = {1'b0, munyt_q} - {7'd0, V0};
    assign y_down   = {1'b0, munyt_q} + {7'd0, vy_q};
    assign down_oob = (y_down + YEXT) > YMAX;
    assign vy_sum   = {1'b0, vy_q} + {1'b0, G};
    assign vy_fall  = (vy_sum > {1'b0, VMAX}) ? VMAX : vy_sum[3:0];

`ifdef MUNECO_DOUBLE_JUMP_EN
    logic armed_q;
    assign air_jump = jump_req_q & armed_q &
                      ((state_q == ST_JUMP) || ((state_q == ST_FALL) && !bus.stand));
`else
    assign air_jump = 1'b0;
`endif
    assign launch = ((state_q == ST_STAND) && jump_req_q) || air_jump;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FALL;
            munyt_q    <= 10'(Y_START);
            vy_q       <= 4'd0;
            jump_req_q <= 1'b0;
            rgb_q      <= COLOR_RST;
            dead_q     <= 1'b0;
`ifdef MUNECO_DOUBLE_JUMP_EN
            armed_q    <= 1'b1;
`endif
        end else if (state_q != ST_DEAD) begin
            jump_req_q <= jump_req_q | jump_pulse;
            if (bus.refr_tick && (bus.color_sel != 3'b000)) begin
                rgb_q <= bus.color_sel;
            end
            if (bus.over) begin
                state_q    <= ST_DEAD;
                dead_q     <= 1'b1;
                jump_req_q <= 1'b0;
            end else if (bus.refr_tick) begin
                if (launch) begin
                    jump_req_q <= jump_pulse;
`ifdef MUNECO_DOUBLE_JUMP_EN
                    if (state_q != ST_STAND) armed_q <= 1'b0;
`endif
                    if (y_launch[10]) begin
                        munyt_q <= 10'd0;
                        vy_q    <= 4'd0;
                        state_q <= ST_FALL;
                    end else begin
                        munyt_q <= y_launch[9:0];
                        vy_q    <= V0;
                        state_q <= ST_JUMP;
                    end
                end else begin
                    case (state_q)
                        ST_STAND: begin
                            if (!bus.stand) begin
                                state_q <= ST_FALL;
                                vy_q    <= 4'd0;
                            end
                        end
                        ST_JUMP: begin
                            jump_req_q <= jump_pulse;
                            if (y_up[10]) begin
                                munyt_q <= 10'd0;
                                vy_q    <= 4'd0;
                                state_q <= ST_FALL;
                            end else begin
                                munyt_q <= y_up[9:0];
                                if (vy_q <= G) begin
                                    vy_q    <= 4'd0;
                                    state_q <= ST_FALL;
                                end else begin
                                    vy_q <= vy_q - G;
                                end
                            end
                        end
                        ST_FALL: begin
                            // Landing keeps a pending jump request for the next tick.
                            if (bus.stand) begin
                                state_q <= ST_STAND;
                                vy_q    <= 4'd0;
`ifdef MUNECO_DOUBLE_JUMP_EN
                                armed_q <= 1'b1;
`endif
                            end else begin
                                jump_req_q <= jump_pulse;
                                if (down_oob) begin
                                    state_q    <= ST_DEAD;
                                    dead_q     <= 1'b1;
                                    jump_req_q <= 1'b0;
                                end else begin
                                    munyt_q <= y_down[9:0];
                                    vy_q    <= vy_fall;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.munyt   = munyt_q;
    assign bus.munyb   = munyt_q + 10'(MUN_Y_SIZE - 1);
    assign bus.mun_rgb = rgb_q;
    assign bus.dead    = dead_q;
    assign bus.mun_on  = (bus.pix_x >= 10'(MUN_XL)) && (bus.pix_x <= 10'(MUN_XR)) &&
                         (bus.pix_y >= munyt_q) && (bus.pix_y <= bus.munyb);

endmodule
